// File: rtl/cache_miss_handler.sv
// Miss/refill engine behind a 4-way set-associative cache array. It writes back a dirty victim,
// bursts in the missing line and returns it as a single fill write. Option: CACHE_MISS_CRIT_WORD_EN.
module cache_miss_handler #(
  parameter int TAG_BITS        = 18,
  parameter int INDEX_BITS      = 8,
  parameter int LINE_SIZE_BYTES = 64,
  parameter int DATA_WIDTH      = 32,
  parameter int WAYS            = 4
) (
  input  logic                                                  clk,
  input  logic                                                  rst,
  input  logic                                                  i_miss_valid,
  output logic                                                  o_miss_ready,
  input  logic [TAG_BITS-1:0]                                   i_miss_tag,
  input  logic [INDEX_BITS-1:0]                                 i_miss_index,
  input  logic [$clog2(WAYS)-1:0]                               i_victim_way,
  input  logic                                                  i_victim_dirty,
  input  logic [TAG_BITS-1:0]                                   i_victim_tag,
  input  logic [8*LINE_SIZE_BYTES-1:0]                          i_victim_line,
  output logic                                                  o_mem_req,
  output logic                                                  o_mem_we,
  output logic [TAG_BITS+INDEX_BITS+$clog2(LINE_SIZE_BYTES)-1:0] o_mem_addr,
  input  logic                                                  i_mem_gnt,
  output logic                                                  o_mem_wvalid,
  output logic [DATA_WIDTH-1:0]                                 o_mem_wdata,
  input  logic                                                  i_mem_wready,
  input  logic                                                  i_mem_rvalid,
  input  logic [DATA_WIDTH-1:0]                                 i_mem_rdata,
`ifdef CACHE_MISS_CRIT_WORD_EN
  input  logic [$clog2(LINE_SIZE_BYTES)-2:0]                    i_miss_word,
  output logic                                                  o_crit_valid,
  output logic [DATA_WIDTH-1:0]                                 o_crit_data,
`endif
  output logic                                                  o_fill_valid,
  output logic [INDEX_BITS-1:0]                                 o_fill_index,
  output logic [$clog2(WAYS)-1:0]                               o_fill_way,
  output logic [TAG_BITS-1:0]                                   o_fill_tag,
  output logic [8*LINE_SIZE_BYTES-1:0]                          o_fill_line,
  output logic                                                  o_busy
);
  localparam int OFFSET_BITS = $clog2(LINE_SIZE_BYTES);
  localparam int WAY_BITS    = $clog2(WAYS);
  localparam int BEATS       = LINE_SIZE_BYTES * 8 / DATA_WIDTH;
  localparam int CNT_BITS    = $clog2(BEATS);

  typedef enum logic [2:0] {IDLE, WB_REQ, WB_DATA, RD_REQ, RD_DATA, FILL} state_t;

  typedef struct packed {
    logic [TAG_BITS-1:0]   tag;
    logic [INDEX_BITS-1:0] index;
    logic [WAY_BITS-1:0]   way;
    logic                  dirty;
    logic [TAG_BITS-1:0]   vtag;
  } miss_req_t;

  state_t                             state, state_nxt;
  miss_req_t                          req_q;
  logic [BEATS-1:0][DATA_WIDTH-1:0]   victim_q;
  logic [BEATS-1:0][DATA_WIDTH-1:0]   line_buf;
  logic [CNT_BITS-1:0]                cnt;
  logic                               accept, wbeat, rbeat, last_beat;

  assign accept    = (state == IDLE) && i_miss_valid;
  assign wbeat     = (state == WB_DATA) && i_mem_wready;
  assign rbeat     = (state == RD_DATA) && i_mem_rvalid;
  assign last_beat = (cnt == CNT_BITS'(BEATS - 1));

  // One counter serves both bursts; it wraps to 0 on the last beat of each.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      req_q    <= '0;
      victim_q <= '0;
      line_buf <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        req_q.tag   <= i_miss_tag;
        req_q.index <= i_miss_index;
        req_q.way   <= i_victim_way;
        req_q.dirty <= i_victim_dirty;
        req_q.vtag  <= i_victim_tag;
        victim_q    <= i_victim_line;
        cnt         <= '0;
      end else if (wbeat || rbeat) begin
        cnt <= last_beat ? '0 : cnt + 1'b1;
      end
      if (rbeat) line_buf[cnt] <= i_mem_rdata;
    end
  end

  always_comb begin
    state_nxt    = state;
    o_mem_req    = 1'b0;
    o_mem_we     = 1'b0;
    o_mem_wvalid = 1'b0;
    o_fill_valid = 1'b0;
    o_mem_addr   = {req_q.tag, req_q.index, {OFFSET_BITS{1'b0}}};
    case (state)
      IDLE:    if (i_miss_valid) state_nxt = i_victim_dirty ? WB_REQ : RD_REQ;
      WB_REQ: begin
        o_mem_req  = 1'b1;
        o_mem_we   = 1'b1;
        o_mem_addr = {req_q.vtag, req_q.index, {OFFSET_BITS{1'b0}}};
        if (i_mem_gnt) state_nxt = WB_DATA;
      end
      WB_DATA: begin
        o_mem_wvalid = 1'b1;
        if (i_mem_wready && last_beat) state_nxt = RD_REQ;
      end
      RD_REQ: begin
        o_mem_req = 1'b1;
        if (i_mem_gnt) state_nxt = RD_DATA;
      end
      RD_DATA: if (i_mem_rvalid && last_beat) state_nxt = FILL;
      FILL: begin
        o_fill_valid = 1'b1;
        state_nxt    = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign o_miss_ready = (state == IDLE);
  assign o_busy       = (state != IDLE);
  assign o_mem_wdata  = victim_q[cnt];
  assign o_fill_index = req_q.index;
  assign o_fill_way   = req_q.way;
  assign o_fill_tag   = req_q.tag;
  assign o_fill_line  = line_buf;

`ifdef CACHE_MISS_CRIT_WORD_EN
  localparam int CRIT_BITS = OFFSET_BITS - 1;
  logic [CRIT_BITS-1:0] crit_word_q;

  always_ff @(posedge clk) begin
    if (rst)         crit_word_q <= '0;
    else if (accept) crit_word_q <= i_miss_word;
  end

  // Forwarded straight from the read bus so the requester can restart before the fill.
  assign o_crit_valid = rbeat && (CRIT_BITS'(cnt) == crit_word_q);
  assign o_crit_data  = o_crit_valid ? i_mem_rdata : '0;
`endif
endmodule

// File: tb/tb_cache_miss_handler.sv
// Directed bench for cache_miss_handler: a cycle-stepped memory responder plus hand-computed
// addresses, beat data and fill latency.
module tb_cache_miss_handler;
  localparam int LINE_BITS = 512;

  logic         clk = 1'b0;
  logic         rst;
  logic         miss_valid, miss_ready;
  logic [17:0]  miss_tag, victim_tag, fill_tag;
  logic [7:0]   miss_index, fill_index;
  logic [1:0]   victim_way, fill_way;
  logic         victim_dirty;
  logic [LINE_BITS-1:0] victim_line, fill_line;
  logic         mem_req, mem_we, mem_gnt, mem_wvalid, mem_wready, mem_rvalid;
  logic [31:0]  mem_addr, mem_wdata, mem_rdata;
  logic         fill_valid, busy;
`ifdef CACHE_MISS_CRIT_WORD_EN
  logic [4:0]   miss_word;
  logic         crit_valid;
  logic [31:0]  crit_data;
`endif

  cache_miss_handler dut (
    .clk(clk), .rst(rst),
    .i_miss_valid(miss_valid), .o_miss_ready(miss_ready),
    .i_miss_tag(miss_tag), .i_miss_index(miss_index),
    .i_victim_way(victim_way), .i_victim_dirty(victim_dirty),
    .i_victim_tag(victim_tag), .i_victim_line(victim_line),
    .o_mem_req(mem_req), .o_mem_we(mem_we), .o_mem_addr(mem_addr), .i_mem_gnt(mem_gnt),
    .o_mem_wvalid(mem_wvalid), .o_mem_wdata(mem_wdata), .i_mem_wready(mem_wready),
    .i_mem_rvalid(mem_rvalid), .i_mem_rdata(mem_rdata),
`ifdef CACHE_MISS_CRIT_WORD_EN
    .i_miss_word(miss_word), .o_crit_valid(crit_valid), .o_crit_data(crit_data),
`endif
    .o_fill_valid(fill_valid), .o_fill_index(fill_index), .o_fill_way(fill_way),
    .o_fill_tag(fill_tag), .o_fill_line(fill_line), .o_busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  int fill_cyc, wr_beats, rd_beats, crit_pulses;
  logic [31:0] seen_wr_addr, seen_rd_addr, seen_crit_data;

  task automatic chk(input string tag, input logic [LINE_BITS-1:0] got, input logic [LINE_BITS-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // wr_pat 0: wready always, 1: toggles 1/0. rd_pat 0: back-to-back, 1: 1,0,0 repeating.
  task automatic do_miss(input logic [17:0] tag, input logic [7:0] idx, input logic [1:0] way,
                         input logic dirty, input logic [17:0] vtag, input logic [31:0] vbase,
                         input logic [31:0] rbase, input int wr_pat, input int rd_pat,
                         input bit spurious, input int abort_at, input bit hold, input logic [4:0] cword);
    logic [LINE_BITS-1:0] vline, eline;
    int cyc, ph;
    bit rd_go, done, spur_done, wtog, rbeat_now, aborted;
    for (int k = 0; k < 16; k++) begin
      vline[k*32 +: 32] = vbase + 32'(k);
      eline[k*32 +: 32] = rbase + 32'(k);
    end
    @(negedge clk);
    miss_valid = 1'b1; miss_tag = tag; miss_index = idx; victim_way = way;
    victim_dirty = dirty; victim_tag = vtag; victim_line = vline;
`ifdef CACHE_MISS_CRIT_WORD_EN
    miss_word = cword;
`endif
    #1;
    chk("ready_at_accept", 512'(miss_ready), 512'(1));
    @(posedge clk);
    cyc = 0; ph = 0; wr_beats = 0; rd_beats = 0; fill_cyc = -1; crit_pulses = 0;
    rd_go = 0; done = 0; spur_done = 0; wtog = 0; aborted = 0;
    while (!done && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (!hold) begin
        miss_valid = 1'b0; miss_tag = ~tag; miss_index = ~idx; victim_way = ~way;
        victim_dirty = ~dirty; victim_tag = ~vtag; victim_line = ~vline;
`ifdef CACHE_MISS_CRIT_WORD_EN
        miss_word = ~cword;
`endif
      end
      mem_gnt = 1'b0; mem_wready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
      rbeat_now = 0;
      if (rd_go && rd_beats < 16) begin
        mem_rvalid = (rd_pat == 0) || (ph % 3 == 0);
        ph++;
        if (mem_rvalid) begin mem_rdata = rbase + 32'(rd_beats); rbeat_now = 1; end
      end
      if (mem_req) begin
        if (mem_we) begin
          seen_wr_addr = mem_addr;
          chk("wr_addr", 512'(mem_addr), 512'({vtag, idx, 6'b0}));
          mem_gnt = 1'b1;
        end else begin
          seen_rd_addr = mem_addr;
          chk("rd_addr", 512'(mem_addr), 512'({tag, idx, 6'b0}));
          chk("wb_before_rd", 512'(wr_beats), dirty ? 512'(16) : 512'(0));
          if (spurious && !spur_done) begin
            mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF; spur_done = 1;
          end else begin
            mem_gnt = 1'b1; rd_go = 1;
          end
        end
      end
      if (mem_wvalid) begin
        chk("wdata", 512'(mem_wdata), 512'(vbase + 32'(wr_beats)));
        mem_wready = (wr_pat == 0) || !wtog;
        wtog = !wtog;
        if (mem_wready) wr_beats++;
      end
      #1;
`ifdef CACHE_MISS_CRIT_WORD_EN
      chk("crit_valid", 512'(crit_valid), 512'(rbeat_now && (rd_beats == int'(cword))));
      if (crit_valid) begin crit_pulses++; seen_crit_data = crit_data; end
`endif
      if (fill_valid) begin
        fill_cyc = cyc;
        chk("rd_beats_at_fill", 512'(rd_beats), 512'(16));
        chk("fill_line", fill_line, eline);
        chk("fill_way", 512'(fill_way), 512'(way));
        chk("fill_index", 512'(fill_index), 512'(idx));
        chk("fill_tag", 512'(fill_tag), 512'(tag));
        done = 1;
      end
      chk("busy_ready", 512'({busy, miss_ready}), 512'(2'b10));
      if (rbeat_now) rd_beats++;
      if (abort_at > 0 && rd_beats == abort_at && !done) begin
        @(posedge clk);
        @(negedge clk);
        mem_rvalid = 1'b0; mem_gnt = 1'b0; rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort_idle", 512'({busy, miss_ready, fill_valid, mem_req, mem_wvalid}), 512'(5'b01000));
        @(negedge clk);
        chk("abort_no_fill", 512'({fill_valid, busy}), 512'(0));
        done = 1; aborted = 1;
      end
    end
    if (!done) chk("timeout", 512'(0), 512'(1));
    if (!aborted) begin
      chk("wr_beats", 512'(wr_beats), dirty ? 512'(16) : 512'(0));
      chk("rd_beats", 512'(rd_beats), 512'(16));
    end
  endtask

  initial begin
    rst = 1'b1; miss_valid = 1'b0; miss_tag = '0; miss_index = '0; victim_way = '0;
    victim_dirty = 1'b0; victim_tag = '0; victim_line = '0;
    mem_gnt = 1'b0; mem_wready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
`ifdef CACHE_MISS_CRIT_WORD_EN
    miss_word = '0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ctrl", 512'({miss_ready, mem_req, mem_we, mem_wvalid, fill_valid, busy}), 512'(6'b100000));
    chk("rst_addr", 512'(mem_addr), 512'(0));
    chk("rst_wdata", 512'(mem_wdata), 512'(0));
    chk("rst_fill_line", fill_line, 512'(0));
    chk("rst_fill_meta", 512'({fill_tag, fill_index, fill_way}), 512'(0));
`ifdef CACHE_MISS_CRIT_WORD_EN
    chk("rst_crit", 512'({crit_valid, crit_data}), 512'(0));
`endif
    rst = 1'b0;

    // Clean miss, immediate grant, back-to-back beats (critical word 5 when enabled).
    do_miss(18'h2A5A5, 8'h12, 2'd2, 1'b0, 18'h0, 32'h0, 32'h100, 0, 0, 0, -1, 0, 5'd5);
    chk("t1_latency", 512'(fill_cyc), 512'(18));
    chk("t1_rd_addr", 512'(seen_rd_addr), 512'(32'hA969_4480));
`ifdef CACHE_MISS_CRIT_WORD_EN
    chk("t6_crit_pulses", 512'(crit_pulses), 512'(1));
    chk("t6_crit_data", 512'(seen_crit_data), 512'(32'h105));
`endif

    // Dirty victim, wready toggling.
    do_miss(18'h0ABCD, 8'h12, 2'd1, 1'b1, 18'h00001, 32'hDEAD_0000, 32'h200, 1, 0, 0, -1, 0, 5'd0);
    chk("t2_wr_addr", 512'(seen_wr_addr), 512'(32'h0000_4480));

    // Gappy rvalid plus a spurious beat during RD_REQ.
    do_miss(18'h13579, 8'hFE, 2'd3, 1'b0, 18'h0, 32'h0, 32'h3000, 0, 1, 1, -1, 0, 5'd15);

    // Reset after beat 7, then a clean miss.
    do_miss(18'h00F0F, 8'h40, 2'd0, 1'b0, 18'h0, 32'h0, 32'h4000, 0, 0, 0, 8, 0, 5'd0);
    do_miss(18'h3FFFF, 8'h01, 2'd1, 1'b0, 18'h0, 32'h0, 32'h5000, 0, 0, 0, -1, 0, 5'd0);
    chk("t4_latency", 512'(fill_cyc), 512'(18));

    // Back-to-back with valid held high through the first miss.
    do_miss(18'h11111, 8'h22, 2'd2, 1'b1, 18'h2AAAA, 32'h6000, 32'h7000, 0, 0, 0, -1, 1, 5'd0);
    do_miss(18'h22222, 8'h33, 2'd3, 1'b0, 18'h0, 32'h0, 32'h8000, 0, 0, 0, -1, 0, 5'd0);
    chk("t5_latency", 512'(fill_cyc), 512'(18));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
